// File: rtl/mac_pkg.sv
// Shared constants for the MAC datapath.
// The lane count and widths are the defaults of the mac parameters. PROD_W is
// the width of one signed-8 x unsigned-8 product. PSUM_W is the width of a
// partial sum over one group of four products. MAC_LATENCY is the depth of the
// valid pipeline.
package mac_pkg;
  localparam int N_LANE        = 16;
  localparam int DW            = 8;
  localparam int PROD_W        = 17;
  localparam int ACC_W         = 20;
  localparam int MAC_LATENCY   = 3;
  localparam int LANES_PER_GRP = 4;
  localparam int PSUM_W        = PROD_W + 2;  // sum of four products
endpackage

// File: rtl/mac_mul.sv
// mul -- combinational lane multiplier.
// It multiplies a signed 8-bit weight by an unsigned 8-bit activation and
// gives a signed 17-bit product.
// Ports:
//   i_w    : weight, signed two's-complement, DW bits
//   i_d    : activation, unsigned, DW bits
//   o_prod : signed product, PROD_W bits
module mul
  import mac_pkg::*;
(
  input  logic        [DW-1:0]     i_w,
  input  logic        [DW-1:0]     i_d,
  output logic signed [PROD_W-1:0] o_prod
);

  logic signed [PROD_W-1:0] w_w_ext;
  logic signed [PROD_W-1:0] w_d_ext;

  // The activation is zero-extended, so it becomes a positive signed operand.
  // The weight is sign-extended. The product of the two fits PROD_W bits.
  assign w_w_ext = PROD_W'($signed(i_w));
  assign w_d_ext = PROD_W'({1'b0, i_d});
  assign o_prod  = w_w_ext * w_d_ext;

endmodule

// File: rtl/mac.sv
// mac -- pipelined dot product with three stages.
// It computes sum(signed win lane i * unsigned din lane i) over N_LANE lanes.
// The stages are:
//   S1: lane products
//   S2: four partial sums
//   S3: final sum
// A result appears 3 cycles after its input vector. The pipeline accepts one
// vector per cycle and has no stall.
// Ports:
//   clk   : clock, rising edge
//   rstn  : asynchronous reset, ACTIVE HIGH despite the name
//   vld_i : input vector valid
//   win   : packed signed weights, lane i = [DW*i +: DW]
//   din   : packed unsigned activations, lane i = [DW*i +: DW]
//   acc_o : signed dot product; holds the last result while vld_o is low
//   vld_o : acc_o valid strobe
module mac #(
  parameter int N_LANE = mac_pkg::N_LANE,
  parameter int DW     = mac_pkg::DW,
  parameter int ACC_W  = mac_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     vld_i,
  input  logic [N_LANE*DW-1:0]     win,
  input  logic [N_LANE*DW-1:0]     din,
  output logic signed [ACC_W-1:0]  acc_o,
  output logic                     vld_o
);

  localparam int PROD_W  = mac_pkg::PROD_W;
  localparam int PSUM_W  = mac_pkg::PSUM_W;
  localparam int GRP     = mac_pkg::LANES_PER_GRP;
  localparam int N_GRP   = N_LANE / GRP;
  localparam int LAT     = mac_pkg::MAC_LATENCY;

  logic signed [PROD_W-1:0] w_prod [N_LANE];
  logic signed [PROD_W-1:0] r_prod [N_LANE];
  logic signed [PSUM_W-1:0] w_psum [N_GRP];
  logic signed [PSUM_W-1:0] r_psum [N_GRP];
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  r_acc;
  logic        [LAT-1:0]    r_vld;

  for (genvar i = 0; i < N_LANE; i++) begin : g_lane
    mul u_mul (
      .i_w    (win[i*DW +: DW]),
      .i_d    (din[i*DW +: DW]),
      .o_prod (w_prod[i])
    );
  end

  // The valid bit advances every cycle, whatever the data is.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) r_vld <= '0;
    else      r_vld <= {r_vld[LAT-2:0], vld_i};
  end

  // S1: lane products.
  always_ff @(posedge clk or posedge rstn) begin
    // NOTE: these arrays are pipeline state, not RAM. They are reset so that
    // acc_o reads 0 after reset.
    if (rstn)       r_prod <= '{default: '0};
    else if (vld_i) r_prod <= w_prod;
  end

  // Group sums. Each addend is sign-extended to the full partial-sum width
  // before it is added.
  always_comb begin
    for (int g = 0; g < N_GRP; g++) begin
      // NOTE: blocking '=' is correct here. Each partial sum builds on the
      // value assigned just above it in the same pass.
      w_psum[g] = '0;
      for (int k = 0; k < GRP; k++)
        w_psum[g] = w_psum[g] + PSUM_W'(r_prod[g*GRP + k]);
    end
  end

  // S2: partial sums.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)          r_psum <= '{default: '0};
    else if (r_vld[0]) r_psum <= w_psum;
  end

  // Final sum. The full range is -522240..+518160, so ACC_W bits never wrap.
  always_comb begin
    w_sum = '0;
    for (int g = 0; g < N_GRP; g++)
      w_sum = w_sum + ACC_W'(r_psum[g]);
  end

  // S3: final sum. It holds while no valid data arrives.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)          r_acc <= '0;
    else if (r_vld[1]) r_acc <= w_sum;
  end

  assign acc_o = r_acc;
  assign vld_o = r_vld[LAT-1];

endmodule

// File: tb/tb_mac.sv
// tb_mac -- self-checking bench for mac.
// A reference model computes each expected result as a plain integer dot
// product. A three-entry queue of expected results sets when each one is due.
module tb_mac;

  localparam int VW = 128;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          vld_i = 1'b0;
  logic [VW-1:0] win = '0;
  logic [VW-1:0] din = '0;
  logic [19:0]   acc_o;
  logic          vld_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit v;
    int val;
  } exp_t;

  exp_t q[$];
  int   model_acc = 0;

  mac u_dut (
    .clk   (clk),
    .rstn  (rstn),
    .vld_i (vld_i),
    .win   (win),
    .din   (din),
    .acc_o (acc_o),
    .vld_o (vld_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dot(input logic [VW-1:0] w, input logic [VW-1:0] d);
    int s = 0;
    for (int i = 0; i < 16; i++)
      s += int'($signed(w[8*i +: 8])) * int'(d[8*i +: 8]);
    return s;
  endfunction

  function automatic logic [VW-1:0] lane0(input logic [7:0] b);
    logic [VW-1:0] v = '0;
    v[7:0] = b;
    return v;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v = {$urandom(), $urandom(), $urandom(), $urandom()};
    // Clear some lanes to exercise zero contributions.
    if ($urandom_range(0, 3) == 0)
      for (int i = 0; i < 16; i++)
        if ($urandom_range(0, 1) == 1) v[8*i +: 8] = 8'h00;
    return v;
  endfunction

  task automatic model_clear();
    exp_t e;
    e.v = 1'b0;
    e.val = 0;
    q = {};
    repeat (3) q.push_back(e);
    model_acc = 0;
  endtask

  // Checks the outputs after the next edge against the model. Then it
  // applies a new input vector, which the following edge samples.
  task automatic step(input logic v, input logic [VW-1:0] w, input logic [VW-1:0] d);
    exp_t e;
    exp_t n;
    @(posedge clk);
    #1;
    e = q.pop_front();
    if (e.v) model_acc = e.val;
    check("vld_o", 32'(vld_o), 32'(e.v));
    check("acc_o", 32'(acc_o), 32'(model_acc[19:0]));
    n.v   = v;
    n.val = dot(w, d);
    q.push_back(n);
    vld_i = v;
    win   = w;
    din   = d;
  endtask

  // Holds reset with random traffic present. The outputs must stay at zero,
  // starting immediately and without waiting for a clock edge.
  task automatic apply_reset(input int ncyc);
    rstn = 1'b1;
    #1;
    check("rst_async_acc", 32'(acc_o), 32'h0);
    check("rst_async_vld", 32'(vld_o), 32'h0);
    repeat (ncyc) begin
      vld_i = 1'b1;
      win   = rnd_vec();
      din   = rnd_vec();
      @(posedge clk);
      #1;
      check("rst_hold_acc", 32'(acc_o), 32'h0);
      check("rst_hold_vld", 32'(vld_o), 32'h0);
    end
    vld_i = 1'b0;
    win   = '0;
    din   = '0;
    @(negedge clk);
    rstn = 1'b0;
    model_clear();
  endtask

  logic [VW-1:0] all80;
  logic [VW-1:0] all7f;
  logic [VW-1:0] allff;
  int            n_vec;

  initial begin
    for (int i = 0; i < 16; i++) begin
      all80[8*i +: 8] = 8'h80;
      all7f[8*i +: 8] = 8'h7F;
      allff[8*i +: 8] = 8'hFF;
    end
    #2;
    apply_reset(5);

    // Single lane: 1 * 5. The result is due exactly three steps later and then holds.
    step(1'b1, lane0(8'h01), lane0(8'h05));
    step(1'b0, '0, '0);
    check("single_early_vld", 32'(vld_o), 32'h0);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    check("single_vld", 32'(vld_o), 32'h1);
    check("single_acc", 32'(acc_o), 32'd5);
    step(1'b0, '0, '0);
    check("single_vld_drop", 32'(vld_o), 32'h0);
    check("single_hold", 32'(acc_o), 32'd5);

    // Extremes of the output range.
    step(1'b1, all80, allff);
    repeat (3) step(1'b0, '0, '0);
    check("max_neg", 32'(acc_o), 32'h80800);
    step(1'b1, all7f, allff);
    repeat (3) step(1'b0, '0, '0);
    check("max_pos", 32'(acc_o), 32'h7E810);

    // Back to back: +10 then -3.
    step(1'b1, lane0(8'h02), lane0(8'h05));
    step(1'b1, lane0(8'hFF), lane0(8'h03));
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    check("stream_a_vld", 32'(vld_o), 32'h1);
    check("stream_a_acc", 32'(acc_o), 32'd10);
    step(1'b0, '0, '0);
    check("stream_b_vld", 32'(vld_o), 32'h1);
    check("stream_b_acc", 32'(acc_o), 32'hFFFFD);
    step(1'b0, '0, '0);
    check("stream_end_vld", 32'(vld_o), 32'h0);

    // Reset while a vector is in flight. That vector must never produce a result.
    step(1'b1, all7f, allff);
    step(1'b0, '0, '0);
    apply_reset(2);
    repeat (4) step(1'b0, '0, '0);
    check("midrst_acc", 32'(acc_o), 32'h0);

    // Random traffic with random gaps.
    n_vec = 0;
    while (n_vec < 1000) begin
      if ($urandom_range(0, 3) != 0) begin
        step(1'b1, rnd_vec(), rnd_vec());
        n_vec++;
      end else begin
        step(1'b0, rnd_vec(), rnd_vec());
      end
    end
    repeat (4) step(1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac.md
MAC -- requirements
Module: mac

Interface
REQ-001 Parameter N_LANE, default 16: number of multiply lanes.
REQ-002 Parameter DW, default 8: operand width per lane.
REQ-003 Parameter ACC_W, default 20: accumulator/output width.
REQ-004 clk  input  1  single clock; all registers on rising edge.
REQ-005 rstn  input  1  asynchronous, active-high reset (asserted = 1), despite the name.
REQ-006 vld_i  input  1  input vector valid, one vector per cycle.
REQ-007 win  input  128  weights; lane i = bits [8i+7:8i], signed two's-complement 8-bit.
REQ-008 din  input  128  activations; lane i = bits [8i+7:8i], unsigned 8-bit.
REQ-009 acc_o  output  20  signed dot product of win and din over 16 lanes.
REQ-010 vld_o  output  1  acc_o valid strobe.

Function
REQ-011 acc_o SHALL equal sum over i=0..15 of signed(win lane i) * unsigned(din lane i), as a 20-bit two's-complement value.
REQ-012 Each product SHALL be computed as 9-bit signed din (zero-extended) times 8-bit signed win, yielding a 17-bit signed result.
REQ-013 Sums SHALL be sign-extended at each adder level; range -522240..+518160 fits 20 bits, so no saturation or wrap occurs.
REQ-014 Pipeline SHALL be 3 stages: S1 registers 16 products; S2 registers four partial sums of 4 products each; S3 registers the final sum into acc_o.
REQ-015 Latency SHALL be exactly 3 cycles: vld_i high at edge N gives vld_o high and a valid acc_o after edge N+3.
REQ-016 Throughput SHALL be one vector per cycle. There is no backpressure or stall input.
REQ-017 The valid bit SHALL shift through a 3-deep register chain every cycle, regardless of data.
REQ-018 Each data stage register SHALL load only when its stage valid bit is set. Otherwise it holds its value.
REQ-019 acc_o SHALL therefore hold the last valid result while vld_o is low.
REQ-020 Back-to-back vectors SHALL produce results in order on consecutive cycles, with no bubbles inserted.
REQ-021 Lanes with win=0 or din=0 SHALL contribute 0. Upper bits of win and din are always used; there is no lane masking.

Reset
REQ-022 While rstn=1, all pipeline registers, acc_o and vld_o SHALL be 0, immediately and independent of clk.
REQ-023 Asserting reset mid-operation SHALL discard all in-flight vectors. No vld_o pulse is produced for them.
REQ-024 After reset deasserts, the first vld_i SHALL produce a result after exactly 3 cycles.

Structure
REQ-025 A shared package SHALL hold N_LANE=16, DW=8, PROD_W=17, ACC_W=20 and MAC_LATENCY=3.
REQ-026 One sub-module, mul, SHALL implement the combinational signed-8 x unsigned-8 to signed-17 multiply; mac instantiates 16 copies.
REQ-027 The adder tree SHALL be written inline in mac.

Verification
REQ-028 Reset: hold rstn=1 with random inputs and vld_i=1 -> acc_o=0 and vld_o=0 throughout.
REQ-029 Single lane: win lane0=0x01, din lane0=0x05, all other lanes 0, vld_i high for 1 cycle -> exactly 3 cycles later vld_o is high for 1 cycle with acc_o=5, and acc_o holds 5 afterwards.
REQ-030 Max negative: all win lanes 0x80, all din lanes 0xFF -> acc_o=20'h80800 (-522240).
REQ-031 Max positive: all win lanes 0x7F, all din lanes 0xFF -> acc_o=20'h7E810 (+518160).
REQ-032 Streaming: vectors A (expected +10) and B (expected -3, e.g. win lane0=0xFF, din lane0=3) on consecutive cycles -> vld_o high on 2 consecutive cycles with acc_o=10 then 20'hFFFFD; matches a reference model over 1000 random vectors with random vld_i gaps.
REQ-033 Reset mid-flight: vld_i pulse, then rstn=1 one cycle later -> vld_o never asserts for that vector, and acc_o=0.
